ps2_rx: RTL and testbench

PS/2 device-to-host receiver. It samples the keyboard's open-drain clock and data lines in the `clk50` domain, deglitches the clock, and deframes 11-bit frames: start 0, 8 data bits LSB first, odd parity, stop 1. Each good byte is presented as a one-cycle strobe with the same byte/valid shape as the UART receiver. On the board it sits directly upstream of the byte consumers: the TX FIFO and the 7-segment shift register. It connects to the currently unused `ps2_data`/`ps2_sdck` pins.

---
 rtl/ps2_rx_if.sv | 15 +
 rtl/ps2_rx.sv | 164 ++++++++++++++++
 tb/tb_ps2_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: received-byte bus out of the PS/2 receiver.
//   q     - last good received byte, holds between frames
//   qv    - one-cycle strobe, q was updated this cycle
//   perr  - one-cycle strobe, parity error (q unchanged)
//   ferr  - one-cycle strobe, framing error or timeout (q unchanged)
// master: the receiver driving the bus; slave: a byte consumer.
interface ps2_rx_if;
    logic [7:0] q;
    logic       qv;
    logic       perr;
    logic       ferr;

    modport master (output q, output qv, output perr, output ferr);
    modport slave  (input  q, input  qv, input  perr, input  ferr);
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver.
// Synchronizes the raw PS/2 clock and data pins into clk50, deglitches the
// clock, and deframes 11-bit frames (start 0, 8 data LSB first, odd parity,
// stop 1). Good bytes appear on bus.q with a one-cycle bus.qv strobe; bad
// frames give a one-cycle bus.perr or bus.ferr strobe instead.
// Ports:
//   clk50    - system clock, all logic on posedge
//   nrst     - synchronous active-low reset
//   ps2_sdck - raw PS/2 clock pin (asynchronous)
//   ps2_data - raw PS/2 data pin (asynchronous)
//   bus      - ps2_rx_if master: q, qv, perr, ferr
module ps2_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic     clk50,
    input  logic     nrst,
    input  logic     ps2_sdck,
    input  logic     ps2_data,
    ps2_rx_if.master bus
);

    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Input synchronizers and clock filter
    logic          sck_m, sck_s, dat_m, dat_s;
    logic          sck_f, sck_f_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    // Frame state and registered outputs
    state_t        state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [7:0]    q_r, q_n;
    logic          qv_r, qv_n, perr_r, perr_n, ferr_r, ferr_n;

    // The filtered clock only follows the synchronized pin once the pin has
    // disagreed with it for FILTER consecutive cycles, so shorter pulses of
    // either polarity are dropped.
    always_ff @(posedge clk50) begin
        if (!nrst) begin
            sck_m    <= 1'b1;
            sck_s    <= 1'b1;
            dat_m    <= 1'b1;
            dat_s    <= 1'b1;
            sck_f    <= 1'b1;
            sck_f_d  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            sck_m   <= ps2_sdck;
            sck_s   <= sck_m;
            dat_m   <= ps2_data;
            dat_s   <= dat_m;
            sck_f_d <= sck_f;
            if (sck_s == sck_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                sck_f    <= sck_s;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall = sck_f_d & ~sck_f;

    always_ff @(posedge clk50) begin
        if (!nrst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tcnt    <= '0;
            q_r     <= '0;
            qv_r    <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par     <= par_n;
            tcnt    <= tcnt_n;
            q_r     <= q_n;
            qv_r    <= qv_n;
            perr_r  <= perr_n;
            ferr_r  <= ferr_n;
        end
    end

    // Frame deframer. Every step is taken on an accepted falling edge; the
    // only exception is the timeout, which can only fire in a cycle without
    // a fall, so the three result strobes can never coincide.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        q_n       = q_r;
        qv_n      = 1'b0;
        perr_n    = 1'b0;
        ferr_n    = 1'b0;
        tcnt_n    = (fall || state == IDLE) ? '0 : tcnt + TW'(1);

        case (state)
            IDLE: begin
                if (fall && !dat_s) begin
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n   = {dat_s, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = dat_s;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (!dat_s) begin
                        ferr_n = 1'b1;
                    end else if (^{shreg, par}) begin
                        q_n  = shreg;
                        qv_n = 1'b1;
                    end else begin
                        perr_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A device that stops clocking mid-frame: drop the partial byte.
        if (state != IDLE && !fall && tcnt == TO_LAST) begin
            state_n = IDLE;
            ferr_n  = 1'b1;
        end
    end

    assign bus.q    = q_r;
    assign bus.qv   = qv_r;
    assign bus.perr = perr_r;
    assign bus.ferr = ferr_r;

endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
// tb_ps2_rx: self-checking bench for ps2_rx with FILTER=8, TIMEOUT=5000.
// Frames are bit-banged at a 400-cycle bit period; a frame-level model
// predicts the outcome of each frame from the PS/2 framing rules.
module tb_ps2_rx;

    logic clk50 = 1'b0;
    logic nrst  = 1'b0;
    logic sck   = 1'b1;
    logic dat   = 1'b1;

    ps2_rx_if bus_if();

    ps2_rx #(.FILTER(8), .TIMEOUT(5000)) dut (
        .clk50    (clk50),
        .nrst     (nrst),
        .ps2_sdck (sck),
        .ps2_data (dat),
        .bus      (bus_if.master)
    );

    always #10 clk50 = ~clk50;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Pulse counters, updated only by the monitor
    int n_qv = 0, n_perr = 0, n_ferr = 0, n_excl = 0;
    // Snapshots, updated only by the main sequence
    int s_qv = 0, s_perr = 0, s_ferr = 0, s_excl = 0;

    logic [7:0] exp_q = 8'h00;

    localparam int OUT_QV   = 0;
    localparam int OUT_PERR = 1;
    localparam int OUT_FERR = 2;
    localparam int OUT_NONE = 3;

    always @(negedge clk50) begin
        if (bus_if.qv)   n_qv++;
        if (bus_if.perr) n_perr++;
        if (bus_if.ferr) n_ferr++;
        if (int'(bus_if.qv) + int'(bus_if.perr) + int'(bus_if.ferr) > 1) n_excl++;
    end

    // Frame-level reference: what a complete frame must produce
    function automatic int frame_outcome(logic [7:0] b, logic p, logic s);
        int ones;
        if (!s) return OUT_FERR;
        ones = $countones(b) + int'(p);
        return (ones % 2 == 1) ? OUT_QV : OUT_PERR;
    endfunction

    function automatic logic odd_par(logic [7:0] b);
        return ($countones(b) % 2 == 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk50);
    endtask

    // Sends the first nbits bits of a frame; glitch_bit >= 0 inserts a
    // 7-cycle high glitch inside that bit's low clock phase.
    task automatic applyStimulus(input logic [7:0] b, input logic p, input logic s,
                                 input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits = {s, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dat = bits[i];
            wait_cycles(100);
            sck = 1'b0;
            if (i == glitch_bit) begin
                wait_cycles(50);
                sck = 1'b1;
                wait_cycles(7);
                sck = 1'b0;
                wait_cycles(143);
            end else begin
                wait_cycles(200);
            end
            sck = 1'b1;
            wait_cycles(100);
        end
    endtask

    task automatic checkOutput(input string tag, input int code, input logic [7:0] b);
        if (code == OUT_QV) exp_q = b;
        check({tag, ".qv"},   32'(n_qv - s_qv),     32'(code == OUT_QV));
        check({tag, ".perr"}, 32'(n_perr - s_perr), 32'(code == OUT_PERR));
        check({tag, ".ferr"}, 32'(n_ferr - s_ferr), 32'(code == OUT_FERR));
        check({tag, ".excl"}, 32'(n_excl - s_excl), 32'd0);
        check({tag, ".q"},    32'(bus_if.q),        32'(exp_q));
        s_qv = n_qv; s_perr = n_perr; s_ferr = n_ferr; s_excl = n_excl;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input logic p,
                              input logic s, input int glitch_bit);
        applyStimulus(b, p, s, 11, glitch_bit);
        checkOutput(tag, frame_outcome(b, p, s), b);
    endtask

    initial begin
        logic [7:0] rb;
        logic       rp, rs;
        int         sel;

        $display("[TB] reset");
        wait_cycles(5);
        check("rst.q",    32'(bus_if.q),    32'h0);
        check("rst.qv",   32'(bus_if.qv),   32'h0);
        check("rst.perr", 32'(bus_if.perr), 32'h0);
        check("rst.ferr", 32'(bus_if.ferr), 32'h0);
        nrst = 1'b1;
        wait_cycles(20);

        $display("[TB] single byte");
        send_frame("t1", 8'h1C, 1'b0, 1'b1, -1);

        $display("[TB] back-to-back bytes");
        send_frame("t2a", 8'hF0, 1'b1, 1'b1, -1);
        send_frame("t2b", 8'h1C, 1'b0, 1'b1, -1);

        $display("[TB] parity error");
        send_frame("t3", 8'h1C, 1'b1, 1'b1, -1);

        $display("[TB] stop-bit error then good frame");
        send_frame("t4a", 8'h5A, 1'b1, 1'b0, -1);
        send_frame("t4b", 8'h5A, 1'b1, 1'b1, -1);

        $display("[TB] random frames");
        for (int k = 0; k < 3; k++) begin
            rb  = 8'($urandom);
            sel = int'($urandom_range(0, 3));
            rp  = odd_par(rb) ^ (sel == 0);
            rs  = (sel != 1);
            send_frame($sformatf("rnd%0d", k), rb, rp, rs, -1);
        end

        $display("[TB] glitch rejection");
        dat = 1'b0;
        wait_cycles(100);
        for (int g = 0; g < 3; g++) begin
            sck = 1'b0;
            wait_cycles(7);
            sck = 1'b1;
            wait_cycles(50);
        end
        checkOutput("t5idle", OUT_NONE, 8'h00);
        send_frame("t5a", 8'hA7, odd_par(8'hA7), 1'b1, -1);
        send_frame("t5b", 8'h3C, odd_par(8'h3C), 1'b1, 4);

        $display("[TB] timeout");
        applyStimulus(8'h0F, 1'b0, 1'b1, 5, -1);
        wait_cycles(4600);
        checkOutput("t6early", OUT_NONE, 8'h00);
        wait_cycles(250);
        checkOutput("t6to", OUT_FERR, 8'h00);
        send_frame("t6next", 8'h1C, 1'b0, 1'b1, -1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h96, 1'b1, 1'b1, 5, -1);
        nrst = 1'b0;
        wait_cycles(1);
        nrst = 1'b1;
        exp_q = 8'h00;
        check("t6rst.qv",   32'(bus_if.qv),   32'h0);
        check("t6rst.perr", 32'(bus_if.perr), 32'h0);
        check("t6rst.ferr", 32'(bus_if.ferr), 32'h0);
        wait_cycles(50);
        checkOutput("t6rst", OUT_NONE, 8'h00);
        send_frame("t6after", 8'h69, odd_par(8'h69), 1'b1, -1);

        wait_cycles(20);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
